sd_spi_phy: RTL
===============

Name: sd_spi_phy

Overview:
- Byte-level SPI mode-0 master that drives the SD card pins.
- Sits directly below the SD protocol controller: accepts one byte at a time over a valid/ready handshake, shifts it out on MOSI, and returns the byte sampled from MISO.
- Also generates the SD power-up dummy clocks with CS high.
- Optionally accumulates a CRC16 over data-block bytes.

Parameters:
- CLK_DIV_SLOW, 125: half-period of spi_clk in clk cycles when fast=0 (init / identification mode).
- CLK_DIV_FAST, 1: half-period of spi_clk in clk cycles when fast=1.
- INIT_CLOCK_BYTES, 10: number of 0xFF bytes (8 clocks each) sent by the init sequence.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- fast  input  1  divider select: 1 = CLK_DIV_FAST, 0 = CLK_DIV_SLOW
- cs_assert  input  1  1 = drive spi_cs low for subsequent bytes
- init_start  input  1  pulse: start dummy-clock sequence
- init_done  output  1  one-cycle pulse when init sequence completes
- tx_data  input  8  byte to send
- tx_valid  input  1  tx_data valid
- tx_ready  output  1  engine can accept a byte this cycle
- rx_data  output  8  last received byte
- rx_valid  output  1  one-cycle pulse, rx_data updated
- busy  output  1  init or byte transfer in progress
- crc_clear  input  1  clear CRC accumulator (optional feature)
- crc_sel  input  1  0 = CRC over tx bytes, 1 = over rx bytes (optional feature)
- crc16  output  16  CRC accumulator (optional feature)
- spi_clk  output  1  SD clock
- spi_mosi  output  1  SD data in
- spi_cs  output  1  SD chip select, active low
- spi_miso  input  1  SD data out

Behaviour:
- Reset: rst_n, asynchronous, active-low; clock clk. All state is cleared immediately on reset, including mid-byte or mid-init.
- Reset values: spi_clk=0, spi_mosi=1, spi_cs=1, tx_ready=1, rx_valid=0, rx_data=0x00, busy=0, init_done=0, crc16=0x0000, FSM=IDLE.
- FSM states: IDLE, INIT, SHIFT_LO, SHIFT_HI, DONE.
- IDLE:
  - tx_ready=1, busy=0, spi_clk=0.
  - spi_cs <= ~cs_assert; CS changes only in IDLE, never mid-byte.
  - The divider value (fast ? FAST : SLOW) is latched on leaving IDLE. Changes to fast mid-transfer are ignored.
- Byte accept:
  - Occurs on tx_valid && tx_ready in IDLE (cycle 0).
  - On the next edge: tx_ready=0, busy=1, spi_mosi=tx_data[7], state SHIFT_LO.
- Shift timing:
  - A divider counter counts 0..DIV-1 in each phase.
  - SHIFT_LO to SHIFT_HI at terminal count: spi_clk goes 1 and spi_miso is sampled into the shift register LSB.
  - SHIFT_HI to SHIFT_LO at terminal count: spi_clk goes 0 and MOSI advances to the next bit, MSB first.
  - After the 8th high phase ends, go to DONE: spi_clk=0, rx_data=shift register, rx_valid=1 for exactly one cycle, spi_mosi=1.
  - DONE to IDLE on the next cycle.
  - rx_valid is high in cycle 16*DIV+1 after the accept.
  - The earliest next accept is cycle 16*DIV+2. spi_cs is held low between back-to-back bytes when cs_assert stays 1.
- INIT:
  - Entered from IDLE on init_start. init_start wins over a simultaneous tx_valid; that byte is not accepted.
  - Forces spi_cs=1, spi_mosi=1 and CLK_DIV_SLOW regardless of fast.
  - Generates exactly 8*INIT_CLOCK_BYTES spi_clk pulses, each CLK_DIV_SLOW cycles low then CLK_DIV_SLOW cycles high.
  - tx_ready=0 and busy=1 throughout. No rx_valid is produced.
  - On completion: init_done pulses 1 cycle and the FSM returns to IDLE.
  - init_start outside IDLE is ignored.
- tx_valid while busy: not accepted; tx_data is captured only at accept.
- A DIV value of 0 is illegal. The implementation treats it as 1.

Optional Feature:
- Macro: SD_SPI_PHY_CRC16_EN
- Defined:
  - crc16 is a CRC-16/XMODEM accumulator (poly 0x1021, init 0x0000, MSB first, no reflection, no final XOR).
  - Updated in the DONE cycle with the tx byte (crc_sel=0) or the rx byte (crc_sel=1).
  - crc_clear sets it to 0x0000 on the next edge. Simultaneous crc_clear and update: clear wins.
  - Init dummy bytes never update it.
- Undefined: crc16 is tied to 0x0000; crc_clear and crc_sel are ignored; no CRC logic is synthesized.

Test Plan:
- Reset: assert rst_n=0 mid-byte (DIV=4) -> same cycle spi_cs=1, spi_clk=0, spi_mosi=1; after release tx_ready=1, busy=0, rx_valid=0.
- Init: CLK_DIV_SLOW=4, INIT_CLOCK_BYTES=10, pulse init_start with cs_assert=1 -> 80 spi_clk rising edges, spi_cs=1 and spi_mosi=1 throughout, init_done pulses once 640±2 cycles later, tx_ready=0 until then.
- Single byte: fast=1, DIV=1, cs_assert=1, tx 0xA5, MISO model returns 0x3C -> MOSI at the rising edges = 1,0,1,0,0,1,0,1; rx_data=0x3C with rx_valid in cycle 17; spi_cs=0 during the transfer.
- Back-to-back: tx_valid held with 0x40 then 0x00, cs_assert=1 -> second accept in cycle 18, spi_cs stays 0 between bytes, two rx_valid pulses; toggling fast mid-byte leaves that byte's timing unchanged.
- Collision: init_start and tx_valid in the same cycle -> INIT runs, the byte is accepted only after init_done.
- CRC (macro defined): crc_clear, then tx "123456789" (0x31..0x39) with crc_sel=0 -> crc16=0x31C3; with the macro undefined -> crc16=0x0000.

Source files
------------

// File: rtl/sd_spi_phy.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sd_spi_phy
// Purpose  : SPI mode-0 byte master for SD cards, with power-up dummy clocks.
//            Define SD_SPI_PHY_CRC16_EN to build the CRC-16/XMODEM accumulator.
// Revision : 1.0
// ============================================================================
module sd_spi_phy #(
  parameter int CLK_DIV_SLOW     = 125,
  parameter int CLK_DIV_FAST     = 1,
  parameter int INIT_CLOCK_BYTES = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fast,
  input  logic        cs_assert,
  input  logic        init_start,
  output logic        init_done,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        busy,
  input  logic        crc_clear,
  input  logic        crc_sel,
  output logic [15:0] crc16,
  output logic        spi_clk,
  output logic        spi_mosi,
  output logic        spi_cs,
  input  logic        spi_miso
);

  // A divider of 0 is meaningless, so it behaves as 1.
  localparam int DIV_SLOW    = (CLK_DIV_SLOW < 1) ? 1 : CLK_DIV_SLOW;
  localparam int DIV_FAST    = (CLK_DIV_FAST < 1) ? 1 : CLK_DIV_FAST;
  localparam int DIV_MAX     = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int DW          = $clog2(DIV_MAX + 1);
  localparam int INIT_PULSES = 8 * ((INIT_CLOCK_BYTES < 1) ? 1 : INIT_CLOCK_BYTES);
  localparam int PW          = $clog2(INIT_PULSES);

  localparam logic [DW-1:0] C_DIV_SLOW  = DW'(DIV_SLOW);
  localparam logic [DW-1:0] C_DIV_FAST  = DW'(DIV_FAST);
  localparam logic [PW-1:0] C_INIT_LAST = PW'(INIT_PULSES - 1);
  localparam logic [PW-1:0] C_BYTE_LAST = PW'(7);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT     = 3'd1,
    S_SHIFT_LO = 3'd2,
    S_SHIFT_HI = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [7:0]      txsh_q, txsh_d;
  logic [7:0]      rxsh_q, rxsh_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            init_done_q, init_done_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic            cs_q, cs_d;

  logic            w_cnt_tc;
  logic [PW-1:0]   w_pcnt_last;

  assign w_cnt_tc    = (cnt_q == (div_q - DW'(1)));
  assign w_pcnt_last = (state_q == S_INIT) ? C_INIT_LAST : C_BYTE_LAST;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    pcnt_d      = pcnt_q;
    txsh_d      = txsh_q;
    rxsh_d      = rxsh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    init_done_d = 1'b0;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    cs_d        = cs_q;

    case (state_q)
      S_IDLE: begin
        sclk_d = 1'b0;
        mosi_d = 1'b1;
        cs_d   = ~cs_assert;
        cnt_d  = '0;
        pcnt_d = '0;
        if (init_start) begin
          state_d = S_INIT;
          cs_d    = 1'b1;
          div_d   = C_DIV_SLOW;
        end else if (tx_valid) begin
          state_d = S_SHIFT_LO;
          div_d   = fast ? C_DIV_FAST : C_DIV_SLOW;
          mosi_d  = tx_data[7];
          txsh_d  = {tx_data[6:0], 1'b0};
        end
      end

      // Dummy clocks reuse the SCK level as the phase flag.
      S_INIT: begin
        cs_d   = 1'b1;
        mosi_d = 1'b1;
        if (w_cnt_tc) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (pcnt_q == w_pcnt_last) begin
              state_d     = S_IDLE;
              init_done_d = 1'b1;
            end else begin
              pcnt_d = pcnt_q + PW'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end

      S_SHIFT_LO: begin
        if (w_cnt_tc) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          rxsh_d  = {rxsh_q[6:0], spi_miso};
          state_d = S_SHIFT_HI;
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end

      S_SHIFT_HI: begin
        if (w_cnt_tc) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (pcnt_q == w_pcnt_last) begin
            state_d    = S_DONE;
            mosi_d     = 1'b1;
            rx_data_d  = rxsh_q;
            rx_valid_d = 1'b1;
          end else begin
            pcnt_d  = pcnt_q + PW'(1);
            mosi_d  = txsh_q[7];
            txsh_d  = {txsh_q[6:0], 1'b0};
            state_d = S_SHIFT_LO;
          end
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= C_DIV_SLOW;
      cnt_q       <= '0;
      pcnt_q      <= '0;
      txsh_q      <= '0;
      rxsh_q      <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      init_done_q <= 1'b0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b1;
      cs_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      pcnt_q      <= pcnt_d;
      txsh_q      <= txsh_d;
      rxsh_q      <= rxsh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      init_done_q <= init_done_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      cs_q        <= cs_d;
    end
  end

  assign tx_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign init_done = init_done_q;
  assign spi_clk   = sclk_q;
  assign spi_mosi  = mosi_q;
  assign spi_cs    = cs_q;

`ifdef SD_SPI_PHY_CRC16_EN
  logic [15:0] crc_q, crc_d;
  logic [7:0]  txbyte_q;

  // CRC-16/XMODEM, one byte per call, MSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
    logic [15:0] r;
    r = crc_in ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (crc_clear) begin
      crc_d = 16'h0000;
    end else if (state_q == S_DONE) begin
      crc_d = crc16_byte(crc_q, crc_sel ? rx_data_q : txbyte_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q    <= 16'h0000;
      txbyte_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
      if (state_q == S_IDLE && !init_start && tx_valid) begin
        txbyte_q <= tx_data;
      end
    end
  end

  assign crc16 = crc_q;
`else
  logic unused_crc_inputs;
  assign unused_crc_inputs = ^{crc_clear, crc_sel};
  assign crc16             = 16'h0000;
`endif

endmodule
`default_nettype wire
